// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and I2S framing constants
package audio_pkg;

    localparam int AUDIO_SAMPLE_W   = 16;
    localparam int AUDIO_I2S_SLOT_W = 32;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t l;
        audio_sample_t r;
    } audio_stereo_t;

endpackage

// File: rtl/audio_i2s_clkgen.sv
// rtl/audio_i2s_clkgen.sv - divides clk down to an I2S bit clock and flags its falling edges
module audio_i2s_clkgen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic sclk,
    output logic fall
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc   = (div_cnt == CW'(HALF_DIV - 1));
    // Strobe is true in the cycle whose closing edge takes sclk from 1 to 0.
    assign fall = tc & sclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - one-deep stereo holding register feeding a Philips I2S master serializer
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = AUDIO_SAMPLE_W,
    parameter int SLOT_WIDTH    = AUDIO_I2S_SLOT_W,
    parameter int SCLK_HALF_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_sclk,
    output logic                    i2s_lrck,
    output logic                    i2s_sdata,
    output logic                    underrun,
    output logic                    overrun
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int BW      = $clog2(FRAME_W);

    logic                    fall;
    logic                    load;
    logic                    full;
    logic                    full_nxt;
    logic [BW-1:0]           bit_cnt;
    logic [BW-1:0]           bit_nxt;
    logic [BW-1:0]           slot_pos;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
    logic [SAMPLE_WIDTH-1:0] cur_l, cur_r;
    logic [SAMPLE_WIDTH-1:0] frame_l, frame_r;
    logic [SAMPLE_WIDTH-1:0] word;
    logic [SAMPLE_WIDTH-1:0] shifted;
    logic                    next_bit;

    audio_i2s_clkgen #(
        .HALF_DIV (SCLK_HALF_DIV)
    ) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .sclk  (i2s_sclk),
        .fall  (fall)
    );

    assign load    = fall && (bit_cnt == '0);
    assign bit_nxt = (bit_cnt == BW'(FRAME_W - 1)) ? '0 : bit_cnt + 1'b1;

    // A write always leaves the register full, even when a load drains it on the same edge.
    assign full_nxt = sample_valid ? 1'b1 : (load ? 1'b0 : full);

    // Pair that will be on the wire after this edge; an empty load keeps the previous frame.
    assign frame_l = (load && full) ? hold_l : cur_l;
    assign frame_r = (load && full) ? hold_r : cur_r;

    // The bit driven at the new count b is frame bit b-1, which is the current bit_cnt.
    // Shifting past the sample width naturally yields the zero padding.
    always_comb begin
        slot_pos = bit_cnt;
        word     = frame_l;
        if (bit_cnt >= BW'(SLOT_WIDTH)) begin
            slot_pos = bit_cnt - BW'(SLOT_WIDTH);
            word     = frame_r;
        end
        shifted  = word << slot_pos;
        next_bit = shifted[SAMPLE_WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            i2s_lrck     <= 1'b0;
            i2s_sdata    <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
            full         <= 1'b0;
            sample_ready <= 1'b1;
            hold_l       <= '0;
            hold_r       <= '0;
            cur_l        <= '0;
            cur_r        <= '0;
        end else begin
            underrun     <= load && !full;
            overrun      <= sample_valid && full && !load;
            full         <= full_nxt;
            sample_ready <= !full_nxt;
            if (fall) begin
                bit_cnt   <= bit_nxt;
                i2s_lrck  <= (bit_nxt >= BW'(SLOT_WIDTH));
                i2s_sdata <= next_bit;
            end
            if (load && full) begin
                cur_l <= hold_l;
                cur_r <= hold_r;
            end
            if (sample_valid) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - directed self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_sclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        underrun;
    logic        overrun;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    logic [63:0] sd, lr;
    logic        sc;

    audio_i2s_tx #(
        .SAMPLE_WIDTH  (16),
        .SLOT_WIDTH    (32),
        .SCLK_HALF_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    // Called just after a load edge (b=1); ends on the following b=0 edge.
    task automatic capture(output logic [63:0] s, output logic [63:0] w, output logic sclk_seen);
        sclk_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            s[63-i]   = i2s_sdata;
            w[63-i]   = i2s_lrck;
            sclk_seen = sclk_seen | i2s_sclk;
            if (i < 63) tick(8);
        end
    endtask

    // Expects reset to have just been released; ends on the first load edge.
    task automatic startup(input string t);
        tick(3);
        check({t, "_sclk_e3"}, i2s_sclk, 1'b0);
        tick(1);
        check({t, "_sclk_e4"}, i2s_sclk, 1'b1);
        check({t, "_lrck_e4"}, i2s_lrck, 1'b0);
        tick(3);
        check({t, "_sclk_e7"}, i2s_sclk, 1'b1);
        check({t, "_underrun_e7"}, underrun, 1'b0);
        tick(1);
        check({t, "_sclk_e8"}, i2s_sclk, 1'b0);
        check({t, "_underrun_e8"}, underrun, 1'b1);
        check({t, "_lrck_e8"}, i2s_lrck, 1'b0);
        check({t, "_sdata_e8"}, i2s_sdata, 1'b0);
    endtask

    initial begin
        // Reset values
        tick(3);
        check("rst_sclk", i2s_sclk, 1'b0);
        check("rst_lrck", i2s_lrck, 1'b0);
        check("rst_sdata", i2s_sdata, 1'b0);
        check("rst_ready", sample_ready, 1'b1);
        check("rst_underrun", underrun, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // 1: free-running with no samples
        reset = 1'b0;
        startup("s1");
        capture(sd, lr, sc);
        check("s1_sdata", sd, 64'h0);
        check("s1_lrck", lr, LR_EXP);
        check("s1_sclk_low_at_fall", sc, 1'b0);

        // 2: one pair ahead of the next load
        sample_l = 16'hA5F0; sample_r = 16'h8001; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        check("s2_ready_low", sample_ready, 1'b0);
        tick(7);
        check("s2_ready_at_load", sample_ready, 1'b1);
        check("s2_no_underrun", underrun, 1'b0);
        capture(sd, lr, sc);
        check("s2_sdata", sd, frame_of(16'hA5F0, 16'h8001));
        check("s2_lrck", lr, LR_EXP);

        // 3: starved frame repeats the previous pair
        tick(8);
        check("s3_underrun", underrun, 1'b1);
        capture(sd, lr, sc);
        check("s3_sdata", sd, frame_of(16'hA5F0, 16'h8001));
        check("s3_underrun_cleared", underrun, 1'b0);

        // 4: second valid overwrites the first
        sample_l = 16'h1111; sample_r = 16'h1111; sample_valid = 1'b1;
        tick(1);
        check("s4_overrun_first", overrun, 1'b0);
        sample_l = 16'h2222; sample_r = 16'h2222;
        tick(1);
        sample_valid = 1'b0;
        check("s4_overrun_second", overrun, 1'b1);
        check("s4_ready", sample_ready, 1'b0);
        tick(1);
        check("s4_overrun_pulse", overrun, 1'b0);
        tick(5);
        check("s4_no_underrun", underrun, 1'b0);
        capture(sd, lr, sc);
        check("s4_sdata", sd, frame_of(16'h2222, 16'h2222));

        // 5: write coincident with a load while full
        sample_l = 16'h0F0F; sample_r = 16'h0F0F; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        tick(6);
        sample_l = 16'h7FFF; sample_r = 16'h7FFF; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        check("s5_no_overrun", overrun, 1'b0);
        check("s5_no_underrun", underrun, 1'b0);
        check("s5_full_after", sample_ready, 1'b0);
        capture(sd, lr, sc);
        check("s5_sdata_old", sd, frame_of(16'h0F0F, 16'h0F0F));
        tick(8);
        check("s5_next_no_underrun", underrun, 1'b0);
        check("s5_next_ready", sample_ready, 1'b1);
        capture(sd, lr, sc);
        check("s5_sdata_new", sd, frame_of(16'h7FFF, 16'h7FFF));

        // 6: reset pulse mid-frame at b=20 with the holding register full
        tick(159);
        sample_l = 16'hFFFF; sample_r = 16'hFFFF; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        check("s6_pre_ready", sample_ready, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("s6_sclk", i2s_sclk, 1'b0);
        check("s6_lrck", i2s_lrck, 1'b0);
        check("s6_sdata", i2s_sdata, 1'b0);
        check("s6_ready", sample_ready, 1'b1);
        startup("s6");
        capture(sd, lr, sc);
        check("s6_sdata_frame", sd, 64'h0);
        check("s6_lrck_frame", lr, LR_EXP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
Downstream consumer of the audio mixer's 16-bit output path. It takes a stereo sample pair through a one-deep holding register and serializes it as a Philips I2S master stream. It generates SCLK and LRCK from the single system clock by division. It sits between the mixer output registers and the DAC/HDMI audio pins.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample, two's complement, MSB first.
SLOT_WIDTH, 32, SCLK periods per channel slot; SLOT_WIDTH >= SAMPLE_WIDTH; unused LSB positions are sent as 0.
SCLK_HALF_DIV, 4, clk cycles per SCLK half-period; must be >= 1.

Ports:
clk  in  1  system clock; every register is on its rising edge.
reset  in  1  synchronous, active-high reset.
sample_l  in  SAMPLE_WIDTH  left sample.
sample_r  in  SAMPLE_WIDTH  right sample.
sample_valid  in  1  qualifies sample_l/sample_r for one clk.
sample_ready  out  1  holding register empty.
i2s_sclk  out  1  bit clock.
i2s_lrck  out  1  word select; 0 = left, 1 = right.
i2s_sdata  out  1  serial data; changes on the SCLK falling edge.
underrun  out  1  1-clk pulse when a frame load finds the holding register empty.
overrun  out  1  1-clk pulse when sample_valid arrives while the holding register is full.

Behaviour:
- Reset values: sclk=0, lrck=0, sdata=0, underrun=0, overrun=0, sample_ready=1; div_cnt=0, bit_cnt=0, holding register=0, full=0, shift register=0. Reset mid-frame aborts the frame immediately with no partial completion.
- Divider: div_cnt counts 0..SCLK_HALF_DIV-1. At terminal count it wraps to 0 and sclk toggles. SCLK period = 2*SCLK_HALF_DIV clk cycles.
- Fall event: the cycle in which sclk toggles 1->0. On a fall event bit_cnt advances modulo 2*SLOT_WIDTH. lrck and sdata update on the same clk edge, so all outputs are registered and glitch-free.
- Frame layout: frame bits 0..SLOT-1 carry sample_l MSB-first, zero padded. Frame bits SLOT..2*SLOT-1 carry sample_r the same way.
- At bit_cnt value b: lrck = (b >= SLOT_WIDTH); sdata = frame bit ((b-1) mod 2*SLOT_WIDTH). This gives the standard one-SCLK delay of data after the LRCK transition.
- Frame load happens on the fall event that moves bit_cnt 0->1. The first load occurs 2*SCLK_HALF_DIV clks after reset release.
  - full=1: shift register takes the holding pair and full clears.
  - full=0: the previous frame's samples are reused (zeros after reset) and underrun pulses.
- Holding register: sample_valid latches the pair and sets full.
  - full=1 already and no load in that cycle: the data is overwritten and overrun pulses.
  - Valid in the same cycle as a load: the load takes the old holding contents (or reuses the previous frame if empty); the new pair is written; full ends at 1. This case is not an overrun.
- sample_ready = !full, registered.
- Latency from sample_valid to first MSB on sdata: up to one frame plus 2*SCLK_HALF_DIV clks.

Decomposition:
- Package audio_pkg: AUDIO_SAMPLE_W=16 constant, typedef audio_sample_t (signed 16-bit), typedef audio_stereo_t struct {l, r}, default I2S slot width constant.
- Sub-module audio_i2s_clkgen: owns div_cnt, sclk and the fall-event strobe. It is reusable by a future I2S receiver.

Test Plan:
1. Reset held, then released with no samples -> sclk rises at clk 4, falls at clk 8 and has period 8; lrck=0 for 32 SCLK, then 1 for 32; sdata constant 0; underrun pulses at clk 8.
2. sample_l=16'hA5F0, sample_r=16'h8001 valid before the first fall -> b=1..16 carry 1010010111110000; b=17..32 carry 0; lrck rises at b=32; b=33..48 carry 1000000000000001; sample_ready returns to 1 at the load.
3. No new sample for the second frame -> identical bitstream repeats; underrun pulses once at that frame's load.
4. Two valids (16'h1111, then 16'h2222 on both channels) before one load -> overrun pulses on the second valid; 16'h2222 is transmitted.
5. sample_valid coincident with the load edge while full (held 16'h0F0F, new 16'h7FFF) -> 16'h0F0F is sent this frame and 16'h7FFF next frame; full=1 after the edge; no overrun or underrun.
6. Reset asserted at b=20 for 1 clk -> the next clk shows sclk=0, lrck=0, sdata=0, sample_ready=1; timing then restarts exactly as in scenario 1.
